board_io_ctrl: RTL

Memory-mapped board I/O peripheral for the PicoRV32 SoC on Artix-7 boards. Replaces hard-wired button-to-IRQ and raw LED/switch wiring with a parametrised block containing:
- synchronised, debounced buttons and switches
- per-button edge-selectable latched interrupts with enable and W1C pending registers
- a CPU-writable LED register
Sits on the SoC iomem bus. Its irq output feeds the core's IRQ vector.

---
 rtl/board_io_pkg.sv | 22 ++
 rtl/io_debounce.sv | 59 +++++
 rtl/board_io_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/board_io_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | board_io_pkg : register map and helpers for board_io_ctrl        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package board_io_pkg;

  localparam logic [7:0] LED_OFS       = 8'h00;
  localparam logic [7:0] BTN_STATE_OFS = 8'h04;
  localparam logic [7:0] SW_STATE_OFS  = 8'h08;
  localparam logic [7:0] IRQ_PEND_OFS  = 8'h0C;
  localparam logic [7:0] IRQ_EN_OFS    = 8'h10;
  localparam logic [7:0] EDGE_CFG_OFS  = 8'h14;

  localparam int EDGE_FALL_BASE = 16;

  function automatic int debounce_cnt_width(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/io_debounce.sv
`default_nettype none
// +------------------------------------------------------------------+
// | io_debounce : 2-FF synchroniser plus per-bit stability counter   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module io_debounce
  import board_io_pkg::*;
#(
  parameter int WIDTH           = 1,
  parameter int DEBOUNCE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_stable
);

  localparam int                c_CNT_W = debounce_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
    end
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [c_CNT_W-1:0] r_cnt;
      logic               r_stable;

      // Stable only follows once the synced value has differed for DEBOUNCE_CYCLES edges in a row.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt    <= '0;
          r_stable <= 1'b0;
        end else if (r_sync[gi] == r_stable) begin
          r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
          r_stable <= r_sync[gi];
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + c_CNT_W'(1);
        end
      end

      assign o_stable[gi] = r_stable;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/board_io_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | board_io_ctrl : iomem peripheral for buttons, switches, LEDs, IRQ|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module board_io_ctrl
  import board_io_pkg::*;
#(
  parameter int          NUM_BTN         = 4,
  parameter int          NUM_SW          = 8,
  parameter int          NUM_LED         = 8,
  parameter int          DEBOUNCE_CYCLES = 1000000,
  parameter logic [31:0] BASE_ADDR       = 32'h0300_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               iomem_valid,
  output logic               iomem_ready,
  input  logic [3:0]         iomem_wstrb,
  input  logic [31:0]        iomem_addr,
  input  logic [31:0]        iomem_wdata,
  output logic [31:0]        iomem_rdata,
  input  logic [NUM_BTN-1:0] buttons,
  input  logic [NUM_SW-1:0]  switches,
  output logic [NUM_LED-1:0] leds,
  output logic [NUM_BTN-1:0] irq
);

  logic [NUM_BTN-1:0] w_btn;
  logic [NUM_SW-1:0]  w_sw;

  io_debounce #(.WIDTH(NUM_BTN), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
    .clk(clk), .rst(rst), .i_raw(buttons), .o_stable(w_btn)
  );

  io_debounce #(.WIDTH(NUM_SW), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
    .clk(clk), .rst(rst), .i_raw(switches), .o_stable(w_sw)
  );

  logic               r_ready;
  logic [31:0]        r_rdata;
  logic [NUM_LED-1:0] r_led;
  logic [NUM_BTN-1:0] r_btn_prev;
  logic [NUM_BTN-1:0] r_pend;
  logic [NUM_BTN-1:0] r_en;
  logic [NUM_BTN-1:0] r_edge_rise;
  logic [NUM_BTN-1:0] r_edge_fall;

  logic               w_sel;
  logic               w_wr;
  logic [7:0]         w_ofs;
  logic [NUM_BTN-1:0] w_event;
  logic [NUM_BTN-1:0] w_w1c;
  logic [NUM_LED-1:0] w_led_next;
  logic [31:0]        w_rd_data;
  logic               w_unused;

  // The !r_ready term makes each access a single-cycle pulse even if valid is held.
  assign w_sel   = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]) && !r_ready;
  assign w_wr    = w_sel && (iomem_wstrb != 4'b0000);
  assign w_ofs   = iomem_addr[7:0];
  assign w_event = (w_btn & ~r_btn_prev & r_edge_rise) | (~w_btn & r_btn_prev & r_edge_fall);
  assign w_w1c   = (w_wr && w_ofs == IRQ_PEND_OFS) ? iomem_wdata[NUM_BTN-1:0] : '0;
  assign w_unused = ^{iomem_wdata};

  always_comb begin
    w_led_next = r_led;
    for (int i = 0; i < NUM_LED; i++)
      if (iomem_wstrb[i/8]) w_led_next[i] = iomem_wdata[i];
  end

  always_comb begin
    w_rd_data = '0;
    case (w_ofs)
      LED_OFS:       w_rd_data[NUM_LED-1:0] = r_led;
      BTN_STATE_OFS: w_rd_data[NUM_BTN-1:0] = w_btn;
      SW_STATE_OFS:  w_rd_data[NUM_SW-1:0]  = w_sw;
      IRQ_PEND_OFS:  w_rd_data[NUM_BTN-1:0] = r_pend;
      IRQ_EN_OFS:    w_rd_data[NUM_BTN-1:0] = r_en;
      EDGE_CFG_OFS: begin
        w_rd_data[NUM_BTN-1:0]                   = r_edge_rise;
        w_rd_data[EDGE_FALL_BASE +: NUM_BTN]     = r_edge_fall;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready     <= 1'b0;
      r_rdata     <= '0;
      r_led       <= '0;
      r_btn_prev  <= '0;
      r_pend      <= '0;
      r_en        <= '0;
      r_edge_rise <= '1;
      r_edge_fall <= '0;
    end else begin
      r_ready    <= w_sel;
      r_btn_prev <= w_btn;
      // A new event in the same cycle as a clear leaves the bit set.
      r_pend     <= (r_pend & ~w_w1c) | w_event;
      if (w_sel) r_rdata <= w_rd_data;
      if (w_wr) begin
        case (w_ofs)
          LED_OFS:      r_led <= w_led_next;
          IRQ_EN_OFS:   r_en  <= iomem_wdata[NUM_BTN-1:0];
          EDGE_CFG_OFS: begin
            r_edge_rise <= iomem_wdata[NUM_BTN-1:0];
            r_edge_fall <= iomem_wdata[EDGE_FALL_BASE +: NUM_BTN];
          end
          default: ;
        endcase
      end
    end
  end

  assign iomem_ready = r_ready;
  assign iomem_rdata = r_rdata;
  assign leds        = r_led;
  assign irq         = r_pend & r_en;

endmodule
`default_nettype wire
